hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Producer side of the pipeline-register stall interface. Generates the active-high hold enables `denPC` (PC) and `denIFID` (IF/ID register), plus a bubble-insert flush for ID/EX.
- Detects load-use hazards and HI/LO hazards. Sequences the multi-cycle mult/div busy window.
- Keeps a saturating stall-cycle counter for performance debug.
- Sits beside the ID stage; all outputs feed the register hold/clear inputs of the next cycle.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.
- CNT_W, 4, width of the md busy counter; must hold max(MULT_CYCLES, DIV_CYCLES).
- PERF_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_useRs  input  1  ID instruction reads rs in EX or earlier.
- id_useRt  input  1  ID instruction reads rt in EX or earlier.
- id_isMD  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- ex_memRead  input  1  instruction in EX is a load.
- ex_writeReg  input  5  destination register of the EX instruction.
- md_start  input  1  EX instruction is mult/div; one-cycle pulse.
- md_isDiv  input  1  qualifies md_start: 1 = div, 0 = mult.
- denPC  output  1  1 = PC holds.
- denIFID  output  1  1 = IF/ID register holds.
- flushIDEX  output  1  1 = ID/EX loads a bubble (synchronous clear on the next edge).
- md_busy  output  1  mult/div unit busy.
- stall_cnt  output  PERF_W  total stall cycles since reset, saturating.

Behaviour:
- Reset: sampled only on the rising clk edge while reset==0. On that edge:
  - md counter := 0; FSM := IDLE; stall_cnt := 0.
  - A mult/div in progress is aborted: md_busy is 0 from the next cycle.
- FSM states: IDLE and BUSY.
  - IDLE -> BUSY on an edge with md_start==1; counter := DIV_CYCLES if md_isDiv, else MULT_CYCLES.
  - BUSY: counter decrements every edge. BUSY -> IDLE on the edge where counter goes 1 -> 0.
  - md_busy = (state==BUSY), registered. It is high for exactly N cycles starting the cycle after md_start.
  - md_start while BUSY is ignored: no reload. The ID stall normally prevents this; the bench checks it as an assertion.
- load_use (combinational) = ex_memRead && ex_writeReg!=0 && ((id_useRs && id_rs==ex_writeReg) || (id_useRt && id_rt==ex_writeReg)).
- md_hazard (combinational) = id_isMD && (md_busy || md_start).
- stall = load_use || md_hazard.
- denPC = denIFID = flushIDEX = stall. Outputs are combinational from current inputs and registered state; zero added latency.
- A load-use stall lasts exactly 1 cycle, because the load moves to MEM and ex_memRead drops.
- An md stall lasts until md_busy falls. The ID instruction proceeds in the first cycle with md_busy==0.
- Register $0: never a hazard source, even if id_useRs and id_rs==0.
- Simultaneous load_use and md_hazard: single stall; the counter increments by 1, not 2.
- stall_cnt: +1 on each edge where stall==1 and reset==1. Saturates at all-ones; no wrap.
- During reset (reset==0): outputs still follow the combinational equations from current inputs, with state treated as cleared only after the edge. The pipeline registers are themselves in reset, so this is harmless. The bench ignores stall outputs while reset==0.

Test Plan:
1. Load-use on rs: ex_memRead=1, ex_writeReg=8, id_rs=8, id_useRs=1 for one cycle -> denPC=denIFID=flushIDEX=1 that cycle only; stall_cnt 0->1.
2. $0 and unused operand: ex_writeReg=0 with id_rs=0; then ex_writeReg=9, id_rt=9, id_useRt=0 -> no stall in either case; stall_cnt unchanged.
3. Mult then mflo: md_start=1, md_isDiv=0 at cycle T; id_isMD=1 from T:
   - md_busy high during T+1..T+5.
   - stall high during T..T+5 (6 cycles); stall_cnt=6.
   - Stall drops at T+6.
4. Div busy window: md_start=1, md_isDiv=1 with id_isMD=0 -> md_busy high 10 cycles, no stall. A second md_start at busy cycle 3 -> no reload; md_busy still falls after cycle 10.
5. Reset mid-divide: assert reset=0 for one edge at busy cycle 4 -> md_busy=0, stall_cnt=0 next cycle; FSM in IDLE and accepts a fresh md_start.
6. Saturation: PERF_W=4, hold load_use true for 20 cycles -> stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: ID-stage hazard inputs and stall/flush outputs of the stall controller.
interface hazard_stall_ctrl_if #(parameter int PERF_W = 32);
  logic [4:0] id_rs, id_rt, ex_writeReg;
  logic id_useRs, id_useRt, id_isMD, ex_memRead, md_start, md_isDiv;
  logic denPC, denIFID, flushIDEX, md_busy;
  logic [PERF_W-1:0] stall_cnt;
  modport master(
    output id_rs, id_rt, id_useRs, id_useRt, id_isMD, ex_memRead, ex_writeReg, md_start, md_isDiv,
    input denPC, denIFID, flushIDEX, md_busy, stall_cnt
  );
  modport slave(
    input id_rs, id_rt, id_useRs, id_useRt, id_isMD, ex_memRead, ex_writeReg, md_start, md_isDiv,
    output denPC, denIFID, flushIDEX, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / HI-LO stall generation, mult/div busy window, saturating stall counter.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 32
) (
  input logic clk,
  input logic reset,
  hazard_stall_ctrl_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [PERF_W-1:0] r_perf;
  logic w_load_use, w_md_hazard, w_stall;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_perf  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_perf  <= (w_stall && !(&r_perf)) ? r_perf + PERF_W'(1) : r_perf;
    end
  end
  // md_start is only honoured from IDLE; a start while busy never reloads
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == BUSY) begin
      w_cnt_nxt   = r_cnt - CNT_W'(1);
      w_state_nxt = (r_cnt == CNT_W'(1)) ? IDLE : BUSY;
    end else if (bus.md_start) begin
      w_cnt_nxt   = bus.md_isDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      w_state_nxt = BUSY;
    end
  end
  assign w_load_use = bus.ex_memRead && (bus.ex_writeReg != 5'd0) &&
                      ((bus.id_useRs && bus.id_rs == bus.ex_writeReg) ||
                       (bus.id_useRt && bus.id_rt == bus.ex_writeReg));
  assign w_md_hazard   = bus.id_isMD && ((r_state == BUSY) || bus.md_start);
  assign w_stall       = w_load_use || w_md_hazard;
  assign bus.denPC     = w_stall;
  assign bus.denIFID   = w_stall;
  assign bus.flushIDEX = w_stall;
  assign bus.md_busy   = (r_state == BUSY);
  assign bus.stall_cnt = r_perf;
endmodule
